// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative RV32M multiply/divide unit, fixed 34-cycle latency
// Operands are converted to magnitudes, processed 1 bit/cycle, then sign-corrected.
module muldiv (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [3:0]  rdadr_in,
   output logic        busy,
   output logic        done,
   output logic        regwrite,
   output logic [31:0] result,
   output logic [3:0]  rdadr
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_CALC = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [3:0]  rd_q, rd_d;
   logic [63:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic        bzero_q, bzero_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;
   logic [3:0]  rdadr_q, rdadr_d;

   logic        is_div;
   logic        a_signed, b_signed;
   logic        sa, sb;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_trial, div_diff;
   logic        div_ok;
   logic [63:0] prod_s;
   logic [31:0] quo, rem;

   assign is_div   = op_q[2];
   assign a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                     (op_q == OP_DIV)  || (op_q == OP_REM);
   assign b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
   assign sa       = a_signed & a_q[31];
   assign sb       = b_signed & b_q[31];
   // 0x80000000 negates to itself, which is exactly its unsigned magnitude
   assign a_mag    = sa ? (~a_q + 32'd1) : a_q;
   assign b_mag    = sb ? (~b_q + 32'd1) : b_q;

   // Multiply: acc = {partial product, remaining multiplier bits}
   assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
   // Divide: acc = {partial remainder, dividend bits / quotient bits}
   assign div_trial = acc_q[63:31];
   assign div_diff  = div_trial - {1'b0, b_q};
   assign div_ok    = ~div_diff[32];

   assign prod_s = negq_q ? (~acc_q + 64'd1) : acc_q;
   assign quo    = negq_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign rem    = negr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      rd_d     = rd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      bzero_d  = bzero_q;
      done_d   = 1'b0;
      result_d = result_q;
      rdadr_d  = rdadr_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = funct3;
               a_d     = rs1;
               b_d     = rs2;
               rd_d    = rdadr_in;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            a_d     = a_mag;
            b_d     = b_mag;
            negq_d  = sa ^ sb;
            negr_d  = sa;
            bzero_d = (b_q == 32'd0);
            cnt_d   = 5'd0;
            acc_d   = is_div ? {32'd0, a_mag} : {32'd0, b_mag};
            state_d = S_CALC;
         end
         S_CALC: begin
            if (is_div) begin
               acc_d = {(div_ok ? div_diff[31:0] : div_trial[31:0]), acc_q[30:0], div_ok};
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            unique case (op_q)
               OP_MUL:                      result_d = prod_s[31:0];
               OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[63:32];
               OP_DIV, OP_DIVU:             result_d = bzero_q ? 32'hFFFF_FFFF : quo;
               OP_REM, OP_REMU:             result_d = rem;
               default:                     result_d = prod_s[31:0];
            endcase
            rdadr_d = rd_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= 3'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         rd_q     <= 4'd0;
         acc_q    <= 64'd0;
         cnt_q    <= 5'd0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         bzero_q  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
         rdadr_q  <= 4'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rd_q     <= rd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         bzero_q  <= bzero_d;
         done_q   <= done_d;
         result_q <= result_d;
         rdadr_q  <= rdadr_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign regwrite = done_q;
   assign result   = result_q;
   assign rdadr    = rdadr_q;

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - self-checking bench for muldiv against a cycle-count/arithmetic model
// Directed RV32M cases with literal results plus randomized ops with start noise while busy.
module tb_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic [3:0]  rdadr_in;
   logic        busy, done, regwrite;
   logic [31:0] result;
   logic [3:0]  rdadr;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   muldiv dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .funct3   (funct3),
      .rs1      (rs1),
      .rs2      (rs2),
      .rdadr_in (rdadr_in),
      .busy     (busy),
      .done     (done),
      .regwrite (regwrite),
      .result   (result),
      .rdadr    (rdadr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] p;
      int sa, sb;
      logic ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Timeline model: an accepted op keeps the unit busy 34 cycles, then done pulses once
   logic [31:0] m_result, m_pend;
   logic [3:0]  m_rdadr, m_rdpend;
   logic        m_done;
   int          m_cnt;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         m_cnt    <= 0;
         m_done   <= 1'b0;
         m_result <= 32'd0;
         m_rdadr  <= 4'd0;
         chk_en   <= 1'b1;
      end else begin
         m_done <= 1'b0;
         if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_done   <= 1'b1;
               m_result <= m_pend;
               m_rdadr  <= m_rdpend;
            end
         end else if (start) begin
            m_cnt    <= 34;
            m_pend   <= ref_op(funct3, rs1, rs2);
            m_rdpend <= rdadr_in;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle_outputs", {25'd0, busy, done, regwrite, result, rdadr},
               {25'd0, (m_cnt != 0), m_done, m_done, m_result, m_rdadr});
      end
   end

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         4: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] rd, input logic [31:0] exp,
                         input bit noise);
      int cyc;
      @(negedge clk);
      start = 1'b1; funct3 = op; rs1 = a; rs2 = b; rdadr_in = rd;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (noise && cyc < 33) begin
            start    = 1'($urandom_range(0, 1));
            funct3   = 3'($urandom_range(0, 7));
            rs1      = $urandom;
            rs2      = $urandom;
            rdadr_in = 4'($urandom_range(0, 15));
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({name, "_latency"}, 64'(cyc), 64'd34);
      check({name, "_result"}, {32'd0, result}, {32'd0, exp});
      check({name, "_rdadr"}, {60'd0, rdadr}, {60'd0, rd});
   endtask

   initial begin
      int cyc;
      bit seen_done;
      logic [2:0]  op;
      logic [31:0] a, b;

      reset = 1'b0; start = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0; rdadr_in = 4'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (50) @(negedge clk);
      check("idle_outputs", {25'd0, busy, done, regwrite, result, rdadr}, 64'd0);

      run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 4'd1,  32'hFFFF_FFEB, 1'b0);
      run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 4'd2,  32'h4000_0000, 1'b0);
      run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd3,  32'hFFFF_FFFE, 1'b0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd4,  32'hFFFF_FFFF, 1'b0);
      run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         4'd5,  32'hFFFF_FFFD, 1'b0);
      run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         4'd6,  32'hFFFF_FFFF, 1'b0);
      run_op("divu",   3'd5, 32'd100,        32'd7,         4'd7,  32'd14,        1'b0);
      run_op("remu",   3'd7, 32'd100,        32'd7,         4'd8,  32'd2,         1'b0);
      run_op("divu0",  3'd5, 32'd100,        32'd0,         4'd9,  32'hFFFF_FFFF, 1'b0);
      run_op("remu0",  3'd7, 32'd100,        32'd0,         4'd10, 32'd100,       1'b0);
      run_op("div_ovf",3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 4'd11, 32'h8000_0000, 1'b0);
      run_op("rem_ovf",3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 4'd12, 32'd0,         1'b0);
      run_op("div0_neg",3'd4,32'hFFFF_FFF0,  32'd0,         4'd13, 32'hFFFF_FFFF, 1'b0);
      run_op("rem0_neg",3'd6,32'hFFFF_FFF0,  32'd0,         4'd14, 32'hFFFF_FFF0, 1'b0);

      // Handshake: start at cycle 10 while busy is ignored; start in the done cycle is taken
      @(negedge clk);
      start = 1'b1; funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rdadr_in = 4'd5;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (cyc == 9) begin
            start = 1'b1; funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'd7; rdadr_in = 4'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      check("hs_first_latency", 64'(cyc), 64'd34);
      check("hs_first_result", {32'd0, result}, 64'd333);
      check("hs_first_rdadr", {60'd0, rdadr}, 64'd5);
      start = 1'b1; funct3 = 3'd7; rs1 = 32'd1000; rs2 = 32'd7; rdadr_in = 4'd6;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("hs_b2b_latency", 64'(cyc), 64'd34);
      check("hs_b2b_result", {32'd0, result}, 64'd6);
      check("hs_b2b_rdadr", {60'd0, rdadr}, 64'd6);

      // Reset during the 20th cycle of a DIV aborts it silently
      @(negedge clk);
      start = 1'b1; funct3 = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; rdadr_in = 4'd3;
      @(negedge clk);
      start = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1'b1;
      end
      reset = 1'b0;
      @(negedge clk);
      check("abort_outputs", {25'd0, busy, done, regwrite, result, rdadr}, 64'd0);
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1'b1;
      end
      check("abort_no_done", {63'd0, seen_done}, 64'd0);
      run_op("mul_after_abort", 3'd0, 32'd3, 32'd5, 4'd4, 32'd15, 1'b0);

      for (int k = 0; k < 48; k++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op("rand", op, a, b, 4'($urandom_range(0, 15)), ref_op(op, a, b), 1'b1);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
